// File: rtl/regs_file_pkg.sv
// Shared constants and debug FSM state encoding for the RV32I integer register file.
package regs_file_pkg;

    localparam int ADDR_W  = 5;
    localparam int DATA_W  = 32;
    localparam int REG_NUM = 2 ** ADDR_W;

    localparam logic [ADDR_W-1:0] ZERO_REG  = 5'd0;
    localparam logic [DATA_W-1:0] ZERO_WORD = 32'h0;

    typedef enum logic {
        DBG_IDLE = 1'b0,
        DBG_ACK  = 1'b1
    } dbg_state_t;

endpackage

// File: rtl/regs_dbg_arb.sv
// Debug port arbiter: grants debug reads/writes around core write-back,
// pulses the ack and raises a pipeline hold when a debug write starves.
module regs_dbg_arb
    import regs_file_pkg::*;
#(
    parameter int DBG_WAIT_MAX = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req,
    input  logic we,
    input  logic core_wen,
    output logic grant_rd,
    output logic grant_wr,
    output logic ack,
    output logic hold
);

    localparam logic [7:0] WAIT_MAX = 8'(DBG_WAIT_MAX);

    dbg_state_t state;
    logic [7:0] wait_cnt;
    logic       idle;
    logic       blocked;
    logic       grant;

    // A debug write only loses to a core write; reads never conflict with storage.
    always_comb begin
        idle     = (state == DBG_IDLE);
        grant_rd = idle && req && !we;
        grant_wr = idle && req && we && !core_wen;
        blocked  = idle && req && we && core_wen;
        grant    = grant_rd || grant_wr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= DBG_IDLE;
            ack      <= 1'b0;
            wait_cnt <= 8'd0;
            hold     <= 1'b0;
        end else begin
            ack <= grant;
            case (state)
                DBG_IDLE: if (grant) state <= DBG_ACK;
                DBG_ACK:  state <= DBG_IDLE;
                default:  state <= DBG_IDLE;
            endcase
            // hold rises on the same edge the counter reaches the limit.
            if (grant || !req) begin
                wait_cnt <= 8'd0;
                hold     <= 1'b0;
            end else if (blocked) begin
                if (wait_cnt != 8'hFF) wait_cnt <= wait_cnt + 8'd1;
                if (wait_cnt >= WAIT_MAX - 8'd1) hold <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/regs_file.sv
// RV32I integer register file x0..x31 with a req/ack debug port.
// Define REGS_BYPASS_EN to forward same-cycle write-back data to the read ports.
module regs_file
    import regs_file_pkg::*;
#(
    parameter int DBG_WAIT_MAX = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] reg1_raddr_i,
    input  logic [ADDR_W-1:0] reg2_raddr_i,
    output logic [DATA_W-1:0] reg1_rdata_o,
    output logic [DATA_W-1:0] reg2_rdata_o,
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic [DATA_W-1:0] rd_data_i,
    input  logic              rd_wen_i,
    input  logic              dbg_req_i,
    input  logic              dbg_we_i,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    input  logic [DATA_W-1:0] dbg_wdata_i,
    output logic [DATA_W-1:0] dbg_rdata_o,
    output logic              dbg_ack_o,
    output logic              hold_flag_o
);

    logic [DATA_W-1:0] regs [REG_NUM];
    logic              grant_rd;
    logic              grant_wr;
    logic              core_wr;
    logic              dbg_wr;

    regs_dbg_arb #(
        .DBG_WAIT_MAX(DBG_WAIT_MAX)
    ) u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (dbg_req_i),
        .we       (dbg_we_i),
        .core_wen (rd_wen_i),
        .grant_rd (grant_rd),
        .grant_wr (grant_wr),
        .ack      (dbg_ack_o),
        .hold     (hold_flag_o)
    );

    assign core_wr = rd_wen_i && (rd_addr_i != ZERO_REG);
    assign dbg_wr  = grant_wr && (dbg_addr_i != ZERO_REG);

    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
        if (addr == ZERO_REG) return ZERO_WORD;
`ifdef REGS_BYPASS_EN
        if (core_wr && (rd_addr_i == addr)) return rd_data_i;
`endif
        return regs[addr];
    endfunction

    always_comb begin
        reg1_rdata_o = read_port(reg1_raddr_i);
        reg2_rdata_o = read_port(reg2_raddr_i);
    end

    // grant_wr implies rd_wen_i=0, so the two write sources never collide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_NUM; i++) regs[i] <= ZERO_WORD;
        end else if (core_wr) begin
            regs[rd_addr_i] <= rd_data_i;
        end else if (dbg_wr) begin
            regs[dbg_addr_i] <= dbg_wdata_i;
        end
    end

    // A debug read racing a core write to the same register returns the new value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbg_rdata_o <= ZERO_WORD;
        end else if (grant_rd) begin
            if (dbg_addr_i == ZERO_REG)
                dbg_rdata_o <= ZERO_WORD;
            else if (core_wr && (rd_addr_i == dbg_addr_i))
                dbg_rdata_o <= rd_data_i;
            else
                dbg_rdata_o <= regs[dbg_addr_i];
        end else if (grant_wr) begin
            dbg_rdata_o <= dbg_wdata_i;
        end
    end

endmodule

// File: tb/tb_regs_file.sv
// Scoreboard bench for regs_file: random core/debug traffic against a reference model.
module tb_regs_file;
    import regs_file_pkg::*;

    localparam int WAIT_MAX = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [4:0]  reg1_raddr = '0, reg2_raddr = '0, rd_addr = '0, dbg_addr = '0;
    logic [31:0] reg1_rdata, reg2_rdata, dbg_rdata;
    logic [31:0] rd_data = '0, dbg_wdata = '0;
    logic        rd_wen = 1'b0, dbg_req = 1'b0, dbg_we = 1'b0;
    logic        dbg_ack, hold_flag;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] model_mem [32];
    logic [31:0] exp_q [$];
    logic        exp_ack = 1'b0;
    logic        exp_hold = 1'b0;
    logic        in_ack = 1'b0;
    int          blocked_run = 0;

    regs_file #(.DBG_WAIT_MAX(WAIT_MAX)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .reg1_raddr_i (reg1_raddr),
        .reg2_raddr_i (reg2_raddr),
        .reg1_rdata_o (reg1_rdata),
        .reg2_rdata_o (reg2_rdata),
        .rd_addr_i    (rd_addr),
        .rd_data_i    (rd_data),
        .rd_wen_i     (rd_wen),
        .dbg_req_i    (dbg_req),
        .dbg_we_i     (dbg_we),
        .dbg_addr_i   (dbg_addr),
        .dbg_wdata_i  (dbg_wdata),
        .dbg_rdata_o  (dbg_rdata),
        .dbg_ack_o    (dbg_ack),
        .hold_flag_o  (hold_flag)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] expected_read(input logic [4:0] addr);
        if (addr == 5'd0) return 32'h0;
`ifdef REGS_BYPASS_EN
        if (rd_wen && rd_addr == addr) return rd_data;
`endif
        return model_mem[addr];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) model_mem[i] = 32'h0;
        exp_q.delete();
        exp_ack     = 1'b0;
        exp_hold    = 1'b0;
        in_ack      = 1'b0;
        blocked_run = 0;
    endtask

    // Reference behaviour at one rising edge, from the bench-driven inputs.
    task automatic model_edge();
        logic granted, blocked;
        granted = !in_ack && dbg_req && (!dbg_we || !rd_wen);
        blocked = !in_ack && dbg_req && dbg_we && rd_wen;
        if (granted) begin
            if (dbg_we)                                  exp_q.push_back(dbg_wdata);
            else if (dbg_addr == 5'd0)                   exp_q.push_back(32'h0);
            else if (rd_wen && rd_addr == dbg_addr)      exp_q.push_back(rd_data);
            else                                         exp_q.push_back(model_mem[dbg_addr]);
        end
        if (rd_wen && rd_addr != 5'd0) model_mem[rd_addr] = rd_data;
        if (granted && dbg_we && dbg_addr != 5'd0) model_mem[dbg_addr] = dbg_wdata;
        if (granted || !dbg_req) begin
            blocked_run = 0;
            exp_hold    = 1'b0;
        end else if (blocked) begin
            blocked_run++;
            if (blocked_run >= WAIT_MAX) exp_hold = 1'b1;
        end
        exp_ack = granted;
        in_ack  = granted;
    endtask

    task automatic applyStimulus(input logic req, input logic we, input logic [4:0] daddr,
                                 input logic [31:0] dwdata, input logic wen, input logic [4:0] waddr,
                                 input logic [31:0] wdata, input logic [4:0] r1, input logic [4:0] r2);
        @(negedge clk);
        dbg_req = req; dbg_we = we; dbg_addr = daddr; dbg_wdata = dwdata;
        rd_wen = wen; rd_addr = waddr; rd_data = wdata;
        reg1_raddr = r1; reg2_raddr = r2;
        #1;
        checkOutput("read_port1", reg1_rdata, expected_read(reg1_raddr));
        checkOutput("read_port2", reg2_rdata, expected_read(reg2_raddr));
        @(posedge clk);
        model_edge();
    endtask

    function automatic logic [4:0] pick_addr();
        if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 3));
        return 5'($urandom_range(0, 31));
    endfunction

    // Monitor: ack/hold every cycle, debug read data popped on each ack.
    always @(negedge clk) begin
        logic [31:0] exp_word;
        checkOutput("dbg_ack", 32'(dbg_ack), 32'(exp_ack));
        checkOutput("hold_flag", 32'(hold_flag), 32'(exp_hold));
        if (dbg_ack) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpected_ack: got ack with empty queue, expected none");
            end else begin
                exp_word = exp_q.pop_front();
                checkOutput("dbg_rdata", dbg_rdata, exp_word);
            end
        end
    end

    initial begin
        logic        req_r, we_r, wen_r;
        logic [4:0]  daddr_r, waddr_r, r1_r;
        logic [31:0] dwdata_r;

        model_reset();
        #1 rst_n = 1'b0;
        reg1_raddr = 5'd5; reg2_raddr = 5'd31;
        #1;
        checkOutput("reset_read1", reg1_rdata, 32'h0);
        checkOutput("reset_read2", reg2_rdata, 32'h0);
        checkOutput("reset_dbg_rdata", dbg_rdata, 32'h0);
        checkOutput("reset_ack", 32'(dbg_ack), 32'h0);
        checkOutput("reset_hold", 32'(hold_flag), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Core write then readback of x5
        applyStimulus(0, 0, 0, 0, 1, 5, 32'hDEADBEEF, 5, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 5, 5);
        #1 checkOutput("x5_readback", reg1_rdata, 32'hDEADBEEF);

        // x0 stays zero for core and debug writes
        applyStimulus(0, 0, 0, 0, 1, 0, 32'h1234, 0, 0);
        applyStimulus(1, 1, 0, 32'h55, 0, 0, 0, 0, 0);
        #1 checkOutput("x0_dbg_ack", 32'(dbg_ack), 32'h1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 checkOutput("x0_read1", reg1_rdata, 32'h0);
        checkOutput("x0_read2", reg2_rdata, 32'h0);

        // Debug read racing a core write to x7
        applyStimulus(0, 0, 0, 0, 1, 7, 32'hA5A5A5A5, 7, 0);
        applyStimulus(1, 0, 7, 0, 1, 7, 32'h11, 7, 0);
        #1 checkOutput("race_ack", 32'(dbg_ack), 32'h1);
        checkOutput("race_rdata", dbg_rdata, 32'h11);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 7, 0);
        #1 checkOutput("race_ack_single", 32'(dbg_ack), 32'h0);
        checkOutput("race_x7", reg1_rdata, 32'h11);

        // Starved debug write to x3
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, 1, 3, 32'hCAFE, 1, 9, 32'(i), 3, 9);
            #1;
            if (i == 6) checkOutput("hold_before_limit", 32'(hold_flag), 32'h0);
            if (i == 7) checkOutput("hold_at_limit", 32'(hold_flag), 32'h1);
        end
        applyStimulus(1, 1, 3, 32'hCAFE, 0, 0, 0, 3, 0);
        #1 checkOutput("hold_cleared", 32'(hold_flag), 32'h0);
        checkOutput("starve_ack", 32'(dbg_ack), 32'h1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 3, 0);
        #1 checkOutput("x3_written", reg1_rdata, 32'hCAFE);

        // Reset asserted during the ACK cycle
        applyStimulus(1, 0, 5, 0, 0, 0, 0, 5, 0);
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        checkOutput("rst_ack_drop", 32'(dbg_ack), 32'h0);
        checkOutput("rst_dbg_rdata", dbg_rdata, 32'h0);
        dbg_req = 1'b0;
        for (int a = 0; a < 32; a++) begin
            reg1_raddr = 5'(a);
            #1 checkOutput("rst_reg_zero", reg1_rdata, 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Request held across the ack: second grant one cycle after ACK
        applyStimulus(1, 0, 2, 0, 0, 0, 0, 0, 0);
        #1 checkOutput("b2b_ack1", 32'(dbg_ack), 32'h1);
        applyStimulus(1, 0, 6, 0, 0, 0, 0, 0, 0);
        #1 checkOutput("b2b_gap", 32'(dbg_ack), 32'h0);
        applyStimulus(1, 0, 6, 0, 0, 0, 0, 0, 0);
        #1 checkOutput("b2b_ack2", 32'(dbg_ack), 32'h1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Random traffic; the bench plays requester and ctrl
        req_r = 1'b0; we_r = 1'b0; daddr_r = '0; dwdata_r = '0;
        for (int n = 0; n < 3000; n++) begin
            if (in_ack) begin
                if ($urandom_range(0, 3) == 0) begin
                    req_r = 1'b1; we_r = 1'($urandom_range(0, 1));
                    daddr_r = pick_addr(); dwdata_r = $urandom;
                end else begin
                    req_r = 1'b0;
                end
            end else if (!req_r && $urandom_range(0, 2) == 0) begin
                req_r = 1'b1; we_r = 1'($urandom_range(0, 1));
                daddr_r = pick_addr(); dwdata_r = $urandom;
            end
            wen_r   = exp_hold ? 1'b0 : ($urandom_range(0, 9) < 6);
            waddr_r = ($urandom_range(0, 3) == 0) ? daddr_r : pick_addr();
            r1_r    = ($urandom_range(0, 1) == 1) ? waddr_r : pick_addr();
            applyStimulus(req_r, we_r, daddr_r, dwdata_r, wen_r, waddr_r, $urandom, r1_r, pick_addr());
        end

        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/regs_file.md
Name: regs_file

Overview:
- Integer register file x0..x31 of the RV32I core.
- Consumes the execute stage write-back triple (rd address, rd data, write enable) and serves the two combinational source-operand reads of the decode stage.
- Adds a debug port (req/ack handshake) so a loader or test harness can read and write registers while the core runs.
- Core writes always have priority. A starvation counter raises a pipeline hold request towards ctrl.

Parameters:
- REG_NUM, 32, number of architectural registers.
- DATA_W, 32, register width.
- ADDR_W, 5, register address width; REG_NUM = 2**ADDR_W.
- DBG_WAIT_MAX, 8, consecutive blocked debug-write cycles before hold_flag_o is raised; range 1..255.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- reg1_raddr_i  in  ADDR_W  source 1 address from decode.
- reg2_raddr_i  in  ADDR_W  source 2 address from decode.
- reg1_rdata_o  out  DATA_W  source 1 data, combinational.
- reg2_rdata_o  out  DATA_W  source 2 data, combinational.
- rd_addr_i  in  ADDR_W  write-back address from execute.
- rd_data_i  in  DATA_W  write-back data from execute.
- rd_wen_i  in  1  write-back enable from execute.
- dbg_req_i  in  1  debug request; held until dbg_ack_o.
- dbg_we_i  in  1  debug operation: 1 write, 0 read.
- dbg_addr_i  in  ADDR_W  debug register address.
- dbg_wdata_i  in  DATA_W  debug write data.
- dbg_rdata_o  out  DATA_W  debug read data, registered.
- dbg_ack_o  out  1  one-cycle completion pulse, registered.
- hold_flag_o  out  1  pipeline hold request to ctrl, registered.

Behaviour:
- Clock and reset: one clock, clk; rst_n is asynchronous, active-low.
- Reset values:
  - all registers 0.
  - dbg_rdata_o = 0, dbg_ack_o = 0, hold_flag_o = 0.
  - FSM in IDLE, wait counter 0.
  - reg1/reg2_rdata_o therefore read 0.
- Reset assertion mid-transaction aborts it: no write, no ack.
- Core write: at the rising edge, if rd_wen_i=1 and rd_addr_i≠0, then reg[rd_addr_i] <= rd_data_i.
- x0: writes to address 0 are discarded from any source; reads of address 0 return 0 always.
- Reads: regN_rdata_o = reg[regN_raddr_i], combinational, zero latency.
- Debug FSM, states IDLE and ACK:
  - IDLE, dbg_req_i=1, dbg_we_i=0 (read): always granted. At the edge, dbg_rdata_o <= current value of reg[dbg_addr_i]. If the core writes the same non-zero address at that edge, dbg_rdata_o captures rd_data_i. Go to ACK.
  - IDLE, dbg_req_i=1, dbg_we_i=1, rd_wen_i=0: granted. reg[dbg_addr_i] <= dbg_wdata_i (discarded if addr 0). dbg_rdata_o <= dbg_wdata_i. Go to ACK.
  - IDLE, debug write with rd_wen_i=1: blocked regardless of address. Stay in IDLE; wait counter +1, saturating.
  - ACK: dbg_ack_o=1 for exactly this cycle. New requests are not sampled. Next state IDLE unconditionally. The requester drops dbg_req_i on seeing ack; if dbg_req_i is still high in IDLE, it is a new request.
- Latency: debug ack arrives 1 cycle after grant; minimum 2 cycles between acks.
- Starvation:
  - Wait counter resets to 0 on any grant or when dbg_req_i=0.
  - hold_flag_o <= 1 when the counter reaches DBG_WAIT_MAX; it stays 1 until the debug write is granted.
  - hold_flag_o clears on the grant edge.
  - ctrl is expected to stall the pipeline, which deasserts rd_wen_i.
- Inputs sampled while rst_n=0 are ignored.

Optional Feature:
- Macro: REGS_BYPASS_EN.
- Defined: write-through bypass. If rd_wen_i=1 and rd_addr_i=regN_raddr_i≠0, then regN_rdata_o = rd_data_i in the same cycle.
- Undefined: reads return stored contents only. The new value is visible from the cycle after the write edge.
- Debug-read capture rule is identical in both builds.

Decomposition:
- Shared package/defines:
  - REG_NUM, ADDR_W, DATA_W.
  - ZERO_REG (5'd0) and ZERO_WORD (32'h0).
  - Debug FSM state encodings DBG_IDLE=1'b0, DBG_ACK=1'b1.
- One sub-module, regs_dbg_arb: debug FSM, wait counter, hold_flag_o. It outputs the grant and write strobes to the storage array in regs_file.

Test Plan:
- Reset, then core write x5 = 32'hDEADBEEF; next cycle read port 1 addr 5 -> 32'hDEADBEEF. With REGS_BYPASS_EN the same value is visible in the write cycle.
- Core write x0 = 32'h1234, debug write x0 = 32'h55 -> reg1/reg2 read addr 0 = 0; dbg_ack_o still pulses once.
- Debug read x7 (holding 32'hA5A5A5A5) while the core writes x7 = 32'h11 at the same edge -> dbg_rdata_o = 32'h11, dbg_ack_o high exactly 1 cycle later.
- Debug write x3 = 32'hCAFE with rd_wen_i=1 for 10 cycles, DBG_WAIT_MAX=8:
  - hold_flag_o rises after 8 blocked cycles.
  - After rd_wen_i drops, the write is granted, hold_flag_o clears, ack follows 1 cycle later, and x3 = 32'hCAFE.
- rst_n low in the ACK cycle -> dbg_ack_o drops immediately, all registers read 0, FSM in IDLE.
- dbg_req_i held high across the ack -> a second transaction is granted on the cycle after ACK; acks are 2 cycles apart, never back-to-back.
